// File: rtl/axi4lite_pkg.sv
// ---------------------------------------------------------------------------
// axi4lite_pkg
// Shared definitions for the pin-to-AXI4-Lite bridge:
//   - AXI4-Lite response codes (OKAY / SLVERR)
//   - master FSM state encoding
//   - default address / data widths
// ---------------------------------------------------------------------------
package axi4lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int DEFAULT_ADDR_WIDTH = 2;
    localparam int DEFAULT_DATA_WIDTH = 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_REQ  = 3'd1,
        ST_WR_RESP = 3'd2,
        ST_RD_REQ  = 3'd3,
        ST_RD_RESP = 3'd4,
        ST_DONE    = 3'd5
    } mst_state_e;

endpackage

// File: rtl/axi4lite_regfile_slave.sv
// ---------------------------------------------------------------------------
// axi4lite_regfile_slave
// AXI4-Lite slave backed by a 2^ADDR_WIDTH x DATA_WIDTH register file.
// Ports:
//   i_clk, i_rst               clock, async active-high reset (clears regfile)
//   i_awvalid/o_awready/i_awaddr   write address channel
//   i_wvalid/o_wready/i_wdata      write data channel
//   o_bvalid/i_bready/o_bresp      write response channel
//   i_arvalid/o_arready/i_araddr   read address channel
//   o_rvalid/i_rready/o_rdata/o_rresp  read data channel
// Valid outputs are registered; they never depend combinationally on ready.
// ---------------------------------------------------------------------------
module axi4lite_regfile_slave
    import axi4lite_pkg::*;
#(
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_awvalid,
    output logic                  o_awready,
    input  logic [ADDR_WIDTH-1:0] i_awaddr,
    input  logic                  i_wvalid,
    output logic                  o_wready,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    output logic                  o_bvalid,
    input  logic                  i_bready,
    output logic [1:0]            o_bresp,
    input  logic                  i_arvalid,
    output logic                  o_arready,
    input  logic [ADDR_WIDTH-1:0] i_araddr,
    output logic                  o_rvalid,
    input  logic                  i_rready,
    output logic [DATA_WIDTH-1:0] o_rdata,
    output logic [1:0]            o_rresp
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic                  r_bvalid;
    logic [1:0]            r_bresp;
    logic                  r_rvalid;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [1:0]            r_rresp;
    logic                  w_wr_hs;
    logic                  w_rd_hs;

    // Address and data are accepted together, and only when no response is outstanding.
    assign o_awready = i_awvalid & i_wvalid & ~r_bvalid;
    assign o_wready  = i_awvalid & i_wvalid & ~r_bvalid;
    assign o_arready = ~r_rvalid;

    assign w_wr_hs = i_awvalid & i_wvalid & ~r_bvalid;
    assign w_rd_hs = i_arvalid & ~r_rvalid;

    assign o_bvalid = r_bvalid;
    assign o_bresp  = r_bresp;
    assign o_rvalid = r_rvalid;
    assign o_rdata  = r_rdata;
    assign o_rresp  = r_rresp;

    // Register file storage and write-response channel.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_bvalid <= 1'b0;
            r_bresp  <= RESP_OKAY;
        end else if (w_wr_hs) begin
            r_mem[i_awaddr] <= i_wdata;
            r_bvalid        <= 1'b1;
            r_bresp         <= RESP_OKAY;
        end else if (r_bvalid && i_bready) begin
            r_bvalid <= 1'b0;
        end else begin
            r_bvalid <= r_bvalid;
        end
    end

    // Read-data channel: data registered on the AR handshake, held until rready.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
            r_rresp  <= RESP_OKAY;
        end else if (w_rd_hs) begin
            r_rvalid <= 1'b1;
            r_rdata  <= r_mem[i_araddr];
            r_rresp  <= RESP_OKAY;
        end else if (r_rvalid && i_rready) begin
            r_rvalid <= 1'b0;
        end else begin
            r_rvalid <= r_rvalid;
        end
    end

endmodule

// File: rtl/axi4lite_pin_bridge.sv
// ---------------------------------------------------------------------------
// axi4lite_pin_bridge
// Converts pin-level start commands into AXI4-Lite transactions against an
// internal register-file slave.
// Ports:
//   clk, rst   clock, async active-high reset
//   ena        enable; starts ignored while low
//   ui_in      [0] start_write, [2:1] write_addr, [3:2] read_addr, [4] start_read
//   uio_in     write data (low DATA_WIDTH bits)
//   uio_out    last read data, zero-extended, held until the next read completes
//   uio_oe     0xFF while a read result is valid, else 0x00
//   uo_out     [0] done, [1] busy, [2] resp_err, [7:3] txn count or 0
// Build option: define TXN_COUNT_EN to drive uo_out[7:3] from a 5-bit
// wrapping count of completed transactions.
// ---------------------------------------------------------------------------
module axi4lite_pin_bridge
    import axi4lite_pkg::*;
#(
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe,
    output logic [7:0] uo_out
);

    mst_state_e            r_state;
    mst_state_e            w_next;
    logic                  r_start_wr_q;
    logic                  r_start_rd_q;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  r_aw_done;
    logic                  r_w_done;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_rd_valid;
    logic                  r_resp_err;
    logic                  r_done;
    logic [4:0]            w_cnt;

    logic                  w_wr_start;
    logic                  w_rd_start;
    logic                  w_awvalid, w_awready, w_wvalid, w_wready;
    logic                  w_bvalid, w_bready, w_arvalid, w_arready;
    logic                  w_rvalid, w_rready;
    logic [1:0]            w_bresp, w_rresp;
    logic [DATA_WIDTH-1:0] w_s_rdata;
    logic                  w_aw_hs, w_w_hs;
    logic [7:0]            w_uio_out;
    logic                  w_unused_bits;

    // Rising-edge detect against last cycle's pin value; gated by enable.
    assign w_wr_start = ena & ui_in[0] & ~r_start_wr_q;
    assign w_rd_start = ena & ui_in[4] & ~r_start_rd_q;

    assign w_aw_hs = w_awvalid & w_awready;
    assign w_w_hs  = w_wvalid & w_wready;

    // Master next-state and channel strobes.
    always_comb begin
        w_next    = r_state;
        w_awvalid = 1'b0;
        w_wvalid  = 1'b0;
        w_bready  = 1'b0;
        w_arvalid = 1'b0;
        w_rready  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_wr_start) begin
                    w_next = ST_WR_REQ;     // write wins a simultaneous start
                end else if (w_rd_start) begin
                    w_next = ST_RD_REQ;
                end else begin
                    w_next = ST_IDLE;
                end
            end
            ST_WR_REQ: begin
                // Each channel drops its valid once it has handshaken.
                w_awvalid = ~r_aw_done;
                w_wvalid  = ~r_w_done;
                if ((r_aw_done | w_aw_hs) && (r_w_done | w_w_hs)) begin
                    w_next = ST_WR_RESP;
                end else begin
                    w_next = ST_WR_REQ;
                end
            end
            ST_WR_RESP: begin
                w_bready = 1'b1;
                if (w_bvalid) begin
                    w_next = ST_DONE;
                end else begin
                    w_next = ST_WR_RESP;
                end
            end
            ST_RD_REQ: begin
                w_arvalid = 1'b1;
                if (w_arready) begin
                    w_next = ST_RD_RESP;
                end else begin
                    w_next = ST_RD_REQ;
                end
            end
            ST_RD_RESP: begin
                w_rready = 1'b1;
                if (w_rvalid) begin
                    w_next = ST_DONE;
                end else begin
                    w_next = ST_RD_RESP;
                end
            end
            ST_DONE: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // State register, start-edge history and captured command.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_start_wr_q <= 1'b0;
            r_start_rd_q <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
        end else begin
            r_state      <= w_next;
            r_start_wr_q <= ui_in[0];
            r_start_rd_q <= ui_in[4];
            if (r_state == ST_IDLE && w_wr_start) begin
                r_addr  <= ui_in[ADDR_WIDTH:1];
                r_wdata <= uio_in[DATA_WIDTH-1:0];
            end else if (r_state == ST_IDLE && w_rd_start) begin
                r_addr <= ui_in[ADDR_WIDTH+1:2];
            end else begin
                r_addr <= r_addr;
            end
        end
    end

    // Per-channel handshake tracking inside WR_REQ; cleared on exit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else if (r_state == ST_WR_REQ && w_next == ST_WR_REQ) begin
            r_aw_done <= r_aw_done | w_aw_hs;
            r_w_done  <= r_w_done | w_w_hs;
        end else begin
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end
    end

    // Read result, response error latch and the registered done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata    <= '0;
            r_rd_valid <= 1'b0;
            r_resp_err <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= (r_state == ST_DONE);
            if (r_state == ST_IDLE && w_wr_start) begin
                r_rd_valid <= 1'b0;
            end else if (w_rvalid && w_rready) begin
                r_rdata    <= w_s_rdata;
                r_rd_valid <= 1'b1;
                r_resp_err <= w_rresp[1];
            end else if (w_bvalid && w_bready) begin
                r_resp_err <= w_bresp[1];
            end else begin
                r_rd_valid <= r_rd_valid;
            end
        end
    end

`ifdef TXN_COUNT_EN
    logic [4:0] r_txn_cnt;

    // Completed-transaction counter; wraps naturally at 5 bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_txn_cnt <= 5'd0;
        end else if (r_state == ST_DONE) begin
            r_txn_cnt <= r_txn_cnt + 5'd1;
        end else begin
            r_txn_cnt <= r_txn_cnt;
        end
    end

    assign w_cnt = r_txn_cnt;
`else
    assign w_cnt = 5'd0;
`endif

    // Zero-extend the read result onto the 8-bit bidirectional bus.
    always_comb begin
        w_uio_out                   = 8'h00;
        w_uio_out[DATA_WIDTH-1:0]   = r_rdata;
    end

    assign uio_out = w_uio_out;
    assign uio_oe  = r_rd_valid ? 8'hFF : 8'h00;
    assign uo_out  = {w_cnt, r_resp_err, (r_state != ST_IDLE), r_done};

    assign w_unused_bits = ^{ui_in[7:5], uio_in, w_bresp[0], w_rresp[0]};

    axi4lite_regfile_slave #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_slave (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_awvalid (w_awvalid),
        .o_awready (w_awready),
        .i_awaddr  (r_addr),
        .i_wvalid  (w_wvalid),
        .o_wready  (w_wready),
        .i_wdata   (r_wdata),
        .o_bvalid  (w_bvalid),
        .i_bready  (w_bready),
        .o_bresp   (w_bresp),
        .i_arvalid (w_arvalid),
        .o_arready (w_arready),
        .i_araddr  (r_addr),
        .o_rvalid  (w_rvalid),
        .i_rready  (w_rready),
        .o_rdata   (w_s_rdata),
        .o_rresp   (w_rresp)
    );

endmodule

// File: tb/tb_axi4lite_pin_bridge.sv
// ---------------------------------------------------------------------------
// tb_axi4lite_pin_bridge
// Directed bench for axi4lite_pin_bridge with hand-computed expectations.
// Pin encodings: write addr A -> ui_in = (A<<1)|0x01; read addr A -> (A<<2)|0x10.
// ---------------------------------------------------------------------------
module tb_axi4lite_pin_bridge;

    logic       clk;
    logic       rst;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;
    logic [7:0] uo_out;

    int n_checks;
    int n_errors;
    int done_cnt;
    int base_cnt;

    axi4lite_pin_bridge dut (
        .clk     (clk),
        .rst     (rst),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe),
        .uo_out  (uo_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count done pulses; a one-cycle pulse spans exactly one falling edge.
    always @(negedge clk) begin
        if (uo_out[0] === 1'b1) done_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full transaction: pins asserted for one cycle, done expected on the
    // third edge after the accepting edge.
    task automatic run_txn(input logic [7:0] pins, input logic [7:0] data, input string tag);
        ui_in  = pins;
        uio_in = data;
        tick();
        check_eq({tag, " busy"}, 32'(uo_out[1]), 32'd1);
        ui_in  = 8'h00;
        uio_in = 8'h00;
        tick();
        check_eq({tag, " done@1"}, 32'(uo_out[0]), 32'd0);
        tick();
        check_eq({tag, " done@2"}, 32'(uo_out[0]), 32'd0);
        tick();
        check_eq({tag, " done@3"}, 32'(uo_out[0]), 32'd1);
        tick();
        check_eq({tag, " done@4"}, 32'(uo_out[0]), 32'd0);
        check_eq({tag, " idle"}, 32'(uo_out[1]), 32'd0);
    endtask

    task automatic do_write(input logic [1:0] addr, input logic [7:0] data);
        run_txn(8'h01 | {5'd0, addr, 1'b0}, data, "wr");
    endtask

    task automatic do_read(input logic [1:0] addr, input logic [7:0] exp);
        run_txn(8'h10 | {4'd0, addr, 2'd0}, 8'h00, "rd");
        check_eq("rd data", 32'(uio_out), 32'(exp));
        check_eq("rd oe", 32'(uio_oe), 32'hFF);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        done_cnt = 0;
        rst    = 1'b1;
        ena    = 1'b1;
        ui_in  = 8'h00;
        uio_in = 8'h00;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check_eq("reset uo_out", 32'(uo_out), 32'h00);
        check_eq("reset uio_out", 32'(uio_out), 32'h00);
        check_eq("reset uio_oe", 32'(uio_oe), 32'h00);

        // Basic write then read-back of address 2.
        do_write(2'd2, 8'h04);
        check_eq("wr oe", 32'(uio_oe), 32'h00);
        do_read(2'd2, 8'h04);
        repeat (3) tick();
        check_eq("held data", 32'(uio_out), 32'h04);
        check_eq("held oe", 32'(uio_oe), 32'hFF);

        // Write clears oe but keeps last data on the bus.
        do_write(2'd0, 8'hA5);
        check_eq("wr clr oe", 32'(uio_oe), 32'h00);
        check_eq("wr keep data", 32'(uio_out), 32'h04);
        do_write(2'd3, 8'h3C);
        do_read(2'd0, 8'hA5);
        do_read(2'd3, 8'h3C);
        do_read(2'd1, 8'h00);

        // Simultaneous starts: write to addr 1 wins, read is dropped.
        base_cnt = done_cnt;
        run_txn(8'h13, 8'h77, "both");
        repeat (4) tick();
        check_eq("both one done", 32'(done_cnt - base_cnt), 32'd1);
        check_eq("both is write", 32'(uio_oe), 32'h00);
        do_read(2'd1, 8'h77);

        // Held start: exactly one transaction.
        base_cnt = done_cnt;
        ui_in = 8'h14;
        repeat (10) tick();
        ui_in = 8'h00;
        repeat (4) tick();
        check_eq("hold one done", 32'(done_cnt - base_cnt), 32'd1);
        check_eq("hold data", 32'(uio_out), 32'h77);

        // Start while busy is dropped; write captures data on accept edge only.
        base_cnt = done_cnt;
        ui_in = 8'h03; uio_in = 8'h11;
        tick();
        ui_in = 8'h00; uio_in = 8'hEE;
        tick();
        ui_in = 8'h10;
        tick();
        ui_in = 8'h00;
        repeat (6) tick();
        check_eq("busy drop done", 32'(done_cnt - base_cnt), 32'd1);
        check_eq("busy drop oe", 32'(uio_oe), 32'h00);
        do_read(2'd1, 8'h11);

        // Disabled: start ignored.
        base_cnt = done_cnt;
        ena = 1'b0;
        ui_in = 8'h01;
        tick();
        ui_in = 8'h00;
        repeat (5) tick();
        ena = 1'b1;
        check_eq("ena low", 32'(done_cnt - base_cnt), 32'd0);

        // Reset mid-read aborts immediately and clears the register file.
        base_cnt = done_cnt;
        ui_in = 8'h14;
        tick();
        ui_in = 8'h00;
        tick();
        rst = 1'b1;
        #1;
        check_eq("rst uo_out", 32'(uo_out), 32'h00);
        check_eq("rst uio_out", 32'(uio_out), 32'h00);
        check_eq("rst uio_oe", 32'(uio_oe), 32'h00);
        repeat (4) tick();
        rst = 1'b0;
        repeat (2) tick();
        check_eq("rst no done", 32'(done_cnt - base_cnt), 32'd0);
        do_read(2'd1, 8'h00);

`ifdef TXN_COUNT_EN
        // Counter wraps: 33 completions after reset leaves 1.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        for (int k = 0; k < 33; k++) begin
            ui_in = 8'h01;
            tick();
            ui_in = 8'h00;
            repeat (4) tick();
        end
        check_eq("txn count", 32'(uo_out[7:3]), 32'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/axi4lite_pin_bridge.md
Name: axi4lite_pin_bridge

Overview:
- Tiny-Tapeout style wrapper that converts pin-level start commands into AXI4-Lite transactions.
- An internal AXI4-Lite master drives an internal AXI4-Lite slave register file of 2^ADDR_WIDTH words, each DATA_WIDTH bits wide.
- Write data enters on uio_in. Read data is presented and held on uio_out.
- uo_out[0] pulses when a transaction completes.

Parameters:
- ADDR_WIDTH, 2, word address width; register file depth is 2^ADDR_WIDTH. Legal range 1..2.
- DATA_WIDTH, 8, register width. Legal range 1..8; narrower data is zero-extended onto uio_out.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- ena  in  1  design enable; while low, start commands are ignored (an in-flight transaction still completes).
- ui_in  in  8  command pins:
  - [0] start_write
  - [2:1] write_addr
  - [3:2] read_addr (bit 2 is shared with write_addr by design)
  - [4] start_read
  - [7:5] unused
- uio_in  in  8  write data; uio_in[DATA_WIDTH-1:0] is used.
- uio_out  out  8  last read data, held until the next completed read.
- uio_oe  out  8  0xFF while a valid read result is held; otherwise 0x00.
- uo_out  out  8  status:
  - [0] done
  - [1] busy
  - [2] resp_err
  - [7:3] 0, or transaction counter if TXN_COUNT_EN is defined.

Behaviour:
- Reset (async assert, sync release):
  - All registers cleared to 0, including every register-file word.
  - Master FSM goes to IDLE.
  - uo_out, uio_out and uio_oe are all 0.
- Start detection: start_write and start_read are rising-edge detected against a registered copy. Holding a start high never retriggers a transaction.
- Starts are accepted only when ena=1 and the FSM is in IDLE. Starts arriving while busy are dropped, not queued.
- If start_write and start_read rise on the same edge, the write wins and the read is dropped.
- Address and data are captured into the master on the accepting edge. Later pin changes do not affect the transaction.
- Master FSM states:
  - IDLE
  - WR_REQ: awvalid=wvalid=1
  - WR_RESP: bready=1
  - RD_REQ: arvalid=1
  - RD_RESP: rready=1
  - DONE
- Master transitions:
  - IDLE -> WR_REQ or RD_REQ on an accepted start.
  - WR_REQ -> WR_RESP once both AW and W have handshaken. AW and W may complete in different cycles; each completed one is tracked.
  - WR_RESP -> DONE on bvalid&bready.
  - RD_REQ -> RD_RESP on arvalid&arready.
  - RD_RESP -> DONE on rvalid&rready. rdata is captured into the uio_out register at this point and rd_valid is set.
  - DONE -> IDLE unconditionally after one cycle.
- Slave:
  - awready=wready=1 when both valids are high and no write response is pending. On that edge it writes regfile[awaddr] and asserts bvalid (bresp=OKAY), holding it until bready.
  - arready=1 when no read response is pending. On the handshake edge it registers rdata=regfile[araddr] and asserts rvalid (rresp=OKAY), holding it until rready.
  - Valid signals never depend combinationally on ready.
- Timing: done is high for exactly one cycle, three rising edges after the edge that accepted the start (both reads and writes).
- busy = (FSM != IDLE).
- resp_err = latched bresp[1] or rresp[1] of the last transaction. It is always 0 with this slave but must be wired.
- rd_valid is cleared when a write is accepted, which drops uio_oe to 0x00. uio_out keeps its last value.
- Read-after-write to the same address returns the newly written data.
- Reset asserted mid-transaction aborts it immediately: no done pulse, and register-file contents are cleared.

Optional Feature:
- Macro TXN_COUNT_EN.
  - When defined: a 5-bit counter increments on every done pulse and wraps 31->0. It is reset to 0 and drives uo_out[7:3].
  - When undefined: uo_out[7:3] is constant 0 and no counter logic exists.

Decomposition:
- Package axi4lite_pkg holds:
  - RESP_OKAY=2'b00 and RESP_SLVERR=2'b10
  - the master FSM state enum
  - default ADDR_WIDTH/DATA_WIDTH constants.
- One natural sub-module, axi4lite_regfile_slave: the AXI4-Lite slave plus register file. The master FSM and pin logic stay in the top.

Test Plan:
- Reset then idle -> uo_out=0x00, uio_out=0x00, uio_oe=0x00, busy=0.
- Pulse start_write one cycle with write_addr=2, uio_in=0x04 -> busy goes high; done pulses once exactly 3 edges later; uio_oe stays 0x00.
- Pulse start_read with read_addr=2 -> one done pulse; uio_out=0x04 and uio_oe=0xFF, both held after done falls.
- Write 0xA5 to addr 0 and 0x3C to addr 3, then read both back -> 0xA5 and 0x3C. A read of an unwritten address -> 0x00.
- Raise start_write and start_read on the same edge -> only the write executes (one done). Hold start high for 10 cycles -> one transaction. Pulse a start while busy -> ignored.
- Assert rst mid-read -> outputs 0 immediately and no done. With TXN_COUNT_EN: 33 transactions -> uo_out[7:3]=1.
